// File: rtl/alu_result_fifo.sv
// Result FIFO behind the 4-bit flagged ALU: stores each result with its opcode and flags,
// and keeps sticky flags plus saturating carry/overflow event counters.
module alu_result_fifo #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [W-1:0]               in_result,
  input  logic                       in_carry,
  input  logic                       in_zero,
  input  logic                       in_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_op,
  output logic [W-1:0]               out_result,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic                       out_overflow,
  input  logic                       clr_stat,
  output logic                       sticky_carry,
  output logic                       sticky_overflow,
  output logic                       all_zero,
  output logic [CNT_W-1:0]           carry_cnt,
  output logic [CNT_W-1:0]           ovf_cnt,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         overflow;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             sticky_carry_q, sticky_carry_d;
  logic             sticky_ovf_q, sticky_ovf_d;
  logic             all_zero_q, all_zero_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             push, pop;
  entry_t           head;

  // Handshake status comes from registered occupancy only
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != LW'(0));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head         = mem_q[rd_ptr_q];
  assign out_op       = head.op;
  assign out_result   = head.result;
  assign out_carry    = head.carry;
  assign out_zero     = head.zero;
  assign out_overflow = head.overflow;

  assign sticky_carry    = sticky_carry_q;
  assign sticky_overflow = sticky_ovf_q;
  assign all_zero        = all_zero_q;
  assign carry_cnt       = carry_cnt_q;
  assign ovf_cnt         = ovf_cnt_q;
  assign level           = level_q;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    sticky_carry_d = sticky_carry_q;
    sticky_ovf_d   = sticky_ovf_q;
    all_zero_d     = all_zero_q;
    carry_cnt_d    = carry_cnt_q;
    ovf_cnt_d      = ovf_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Clear first so a same-cycle push still contributes
    if (clr_stat) begin
      sticky_carry_d = 1'b0;
      sticky_ovf_d   = 1'b0;
      all_zero_d     = 1'b1;
      carry_cnt_d    = '0;
      ovf_cnt_d      = '0;
    end
    if (push) begin
      sticky_carry_d = sticky_carry_d | in_carry;
      sticky_ovf_d   = sticky_ovf_d | in_overflow;
      all_zero_d     = all_zero_d & in_zero;
      if (carry_cnt_d != '1) carry_cnt_d = carry_cnt_d + CNT_W'(in_carry);
      if (ovf_cnt_d != '1)   ovf_cnt_d   = ovf_cnt_d + CNT_W'(in_overflow);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      sticky_carry_q <= 1'b0;
      sticky_ovf_q   <= 1'b0;
      all_zero_q     <= 1'b1;
      carry_cnt_q    <= '0;
      ovf_cnt_q      <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      sticky_carry_q <= sticky_carry_d;
      sticky_ovf_q   <= sticky_ovf_d;
      all_zero_q     <= all_zero_d;
      carry_cnt_q    <= carry_cnt_d;
      ovf_cnt_q      <= ovf_cnt_d;
    end
  end

  // Storage needs no reset; entries are only observed while valid
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= '{op: in_op, result: in_result, carry: in_carry,
                           zero: in_zero, overflow: in_overflow};
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized + directed bench for alu_result_fifo against a queue-based reference model;
// a second instance with 2-bit counters exercises counter saturation.
module tb_alu_result_fifo;

  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned EW    = 3 + W + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, out_ready, clr_stat;
  logic [2:0]   in_op;
  logic [W-1:0] in_result;
  logic         in_carry, in_zero, in_overflow;

  logic a_in_ready, a_out_valid, a_out_carry, a_out_zero, a_out_overflow;
  logic [2:0] a_out_op;
  logic [W-1:0] a_out_result;
  logic a_sc, a_so, a_az;
  logic [7:0] a_cc, a_oc;
  logic [2:0] a_level;

  logic b_in_ready, b_out_valid, b_out_carry, b_out_zero, b_out_overflow;
  logic [2:0] b_out_op;
  logic [W-1:0] b_out_result;
  logic b_sc, b_so, b_az;
  logic [1:0] b_cc, b_oc;
  logic [2:0] b_level;

  alu_result_fifo #(.W(W), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_op(in_op), .in_result(in_result), .in_carry(in_carry), .in_zero(in_zero),
    .in_overflow(in_overflow), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_op(a_out_op), .out_result(a_out_result), .out_carry(a_out_carry),
    .out_zero(a_out_zero), .out_overflow(a_out_overflow), .clr_stat(clr_stat),
    .sticky_carry(a_sc), .sticky_overflow(a_so), .all_zero(a_az),
    .carry_cnt(a_cc), .ovf_cnt(a_oc), .level(a_level));

  alu_result_fifo #(.W(W), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_op(in_op), .in_result(in_result), .in_carry(in_carry), .in_zero(in_zero),
    .in_overflow(in_overflow), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_op(b_out_op), .out_result(b_out_result), .out_carry(b_out_carry),
    .out_zero(b_out_zero), .out_overflow(b_out_overflow), .clr_stat(clr_stat),
    .sticky_carry(b_sc), .sticky_overflow(b_so), .all_zero(b_az),
    .carry_cnt(b_cc), .ovf_cnt(b_oc), .level(b_level));

  // Reference model: plain queue of entries plus statistic totals
  logic [EW-1:0] mq[$];
  bit m_sc, m_so, m_az;
  int m_carries, m_ovfs;
  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic model_reset_stats();
    m_sc = 0; m_so = 0; m_az = 1; m_carries = 0; m_ovfs = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(a_out_valid), 32'(mq.size() != 0));
    chk("in_ready",  32'(a_in_ready),  32'(mq.size() != DEPTH));
    chk("level",     32'(a_level),     32'(mq.size()));
    chk("sat_level", 32'(b_level),     32'(mq.size()));
    if (mq.size() != 0) begin
      chk("head", 32'({a_out_op, a_out_result, a_out_carry, a_out_zero, a_out_overflow}), 32'(mq[0]));
      chk("sat_head", 32'({b_out_op, b_out_result, b_out_carry, b_out_zero, b_out_overflow}), 32'(mq[0]));
    end
    chk("sticky_carry",    32'(a_sc), 32'(m_sc));
    chk("sticky_overflow", 32'(a_so), 32'(m_so));
    chk("all_zero",        32'(a_az), 32'(m_az));
    chk("carry_cnt",       32'(a_cc), 32'(sat(m_carries, 255)));
    chk("ovf_cnt",         32'(a_oc), 32'(sat(m_ovfs, 255)));
    chk("sat_carry_cnt",   32'(b_cc), 32'(sat(m_carries, 3)));
    chk("sat_ovf_cnt",     32'(b_oc), 32'(sat(m_ovfs, 3)));
  endtask

  // One clock: drive at negedge, check pre-edge state, advance model, cross posedge
  task automatic cycle(input logic v, input logic [2:0] op, input logic [W-1:0] res,
                       input logic c, input logic z, input logic o,
                       input logic ordy, input logic clr, input logic rstn);
    bit do_push, do_pop;
    in_valid = v; in_op = op; in_result = res; in_carry = c; in_zero = z;
    in_overflow = o; out_ready = ordy; clr_stat = clr; rst_n = rstn;
    #1;
    check_outputs();
    if (!rstn) begin
      mq.delete();
      model_reset_stats();
    end else begin
      do_push = v && (mq.size() < DEPTH);
      do_pop  = ordy && (mq.size() > 0);
      if (clr) model_reset_stats();
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({op, res, c, z, o});
        m_sc = m_sc | c;
        m_so = m_so | o;
        m_az = m_az & z;
        m_carries += int'(c);
        m_ovfs    += int'(o);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [2:0] op, input logic [W-1:0] res,
                      input logic c, input logic z, input logic o, input logic ordy);
    cycle(1'b1, op, res, c, z, o, ordy, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_stat = 1'b0;
    in_op = '0; in_result = '0; in_carry = 1'b0; in_zero = 1'b0; in_overflow = 1'b0;
    model_reset_stats();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Idle after reset
    repeat (3) idle(1'b1);

    // Fill four, refuse a fifth, then drain in order
    push(3'b000, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);
    push(3'b001, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(3'b010, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'b101, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'b111, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) idle(1'b1);
    chk("final_ovf_cnt", 32'(a_oc), 32'd1);
    chk("final_all_zero", 32'(a_az), 32'd0);

    // Full with push and pop together: pop only, then the push lands
    for (int i = 0; i < 4; i++) push(3'(i), 4'(i + 9), 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd6, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3'd6, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) idle(1'b1);

    // Steady streaming at level 2
    push(3'd1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) push(3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    repeat (3) idle(1'b1);

    // Counter saturation, then clear together with a carry push
    cycle(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) push(3'd0, 4'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sat_hold", 32'(b_cc), 32'd3);
    cycle(1'b1, 3'd0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_push_cnt", 32'(b_cc), 32'd1);
    chk("clr_push_sticky", 32'(a_sc), 32'd1);

    // Reset mid-traffic at level 3, then a normal push
    repeat (3) idle(1'b1);
    for (int i = 0; i < 3; i++) push(3'(i), 4'(i), 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 3'd7, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(3'd4, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 3'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 99) != 0));
    end
    idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
